rx_cmd_ctrl: RTL and testbench
==============================

RX_CMD_CTRL -- requirements
Module: rx_cmd_ctrl

Interface
REQ-001 SHALL provide parameter ADDR_W, default 4, register-file address width.
REQ-002 SHALL provide parameter TIMEOUT_CYC, default 1024, clk cycles allowed between bytes of one command (used only under REQ-031).
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports rx_data_valid  in  1  one-cycle pulse per received frame; rx_p_data  in  8  frame payload.
REQ-006 SHALL have ports rx_par_err, rx_stp_err  in  1 each  error flags, qualified by rx_data_valid.
REQ-007 SHALL have ports cfg_prescale  out  6, cfg_par_en  out  1, cfg_par_typ  out  1  receiver configuration.
REQ-008 SHALL have ports rf_wr_en  out  1, rf_rd_en  out  1, rf_addr  out  ADDR_W, rf_wr_data  out  8  register-file access.
REQ-009 SHALL have ports rf_rd_data  in  8, rf_rd_valid  in  1  read return.
REQ-010 SHALL have ports tx_data  out  8, tx_data_valid  out  1, tx_busy  in  1  reply to transmitter.
REQ-011 SHALL have port err_cnt  out  8  count of dropped/bad bytes.

Function
REQ-012 SHALL implement states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND, CFG_DATA.
REQ-013 "Good byte" = rx_data_valid high with rx_par_err and rx_stp_err low; "bad byte" = rx_data_valid high with either error flag high.
REQ-014 IDLE: good byte 0xAA -> WR_ADDR; 0xBB -> RD_ADDR; 0xCC -> CFG_DATA; any other value -> stay IDLE, err_cnt +1.
REQ-015 WR_ADDR: good byte -> latch rf_addr = byte[ADDR_W-1:0], go to WR_DATA.
REQ-016 WR_DATA: good byte -> rf_wr_data = byte, rf_wr_en pulses high exactly one cycle, on the cycle after the byte; return to IDLE.
REQ-017 RD_ADDR: good byte -> latch rf_addr, rf_rd_en pulses one cycle, on the cycle after the byte; go to RD_WAIT.
REQ-018 RD_WAIT: rf_rd_valid high -> latch tx_data = rf_rd_data, go to TX_SEND.
REQ-019 TX_SEND: tx_data_valid held high; transfer completes in the first cycle in which tx_busy is low; tx_data_valid drops and FSM returns to IDLE next cycle; tx_data stable throughout.
REQ-020 CFG_DATA: good byte -> cfg_prescale = 4/8/16/32 for byte[1:0] = 00/01/10/11; cfg_par_en = byte[2]; cfg_par_typ = byte[3]; byte[7:4] ignored; new values on the cycle after the byte; return to IDLE.
REQ-021 Bad byte in IDLE, WR_ADDR, WR_DATA, RD_ADDR or CFG_DATA -> abort to IDLE, no rf/cfg side effect, err_cnt +1.
REQ-022 Any byte (good or bad) arriving in RD_WAIT or TX_SEND SHALL be dropped, err_cnt +1, state unchanged.
REQ-023 err_cnt SHALL saturate at 255 and never wrap.
REQ-024 rf_wr_en and rf_rd_en SHALL never be high in the same cycle; at most one access per command.
REQ-025 rf_rd_valid outside RD_WAIT SHALL be ignored.

Reset
REQ-026 rst high at a rising edge SHALL force IDLE regardless of current state, including mid-command and mid-TX_SEND.
REQ-027 Reset values: cfg_prescale = 8, cfg_par_en = 1, cfg_par_typ = 0, rf_wr_en = rf_rd_en = 0, rf_addr = 0, rf_wr_data = 0, tx_data = 0, tx_data_valid = 0, err_cnt = 0, timeout counter = 0.
REQ-028 A pending read or reply SHALL be discarded by reset; no rf or tx strobe in the cycle after rst deasserts.

Configuration
REQ-029 Macro RX_CMD_TIMEOUT_EN SHALL select inter-byte timeout.
REQ-030 Without RX_CMD_TIMEOUT_EN: no timeout counter exists; a partial command waits indefinitely.
REQ-031 With RX_CMD_TIMEOUT_EN: in WR_ADDR, WR_DATA, RD_ADDR and CFG_DATA, a counter clears on every byte and on state entry; reaching TIMEOUT_CYC without a byte -> IDLE, err_cnt +1, no side effect. RD_WAIT and TX_SEND are never timed out.

Verification
REQ-032 Bytes AA,05,3C -> one rf_wr_en pulse with rf_addr=5, rf_wr_data=0x3C; err_cnt stays 0.
REQ-033 Bytes BB,07; rf_rd_valid with rf_rd_data=0x5A; tx_busy high 10 cycles then low -> tx_data=0x5A, tx_data_valid high until the tx_busy-low cycle, then IDLE.
REQ-034 Byte CC then 0x0B -> cfg_prescale=32, cfg_par_en=0, cfg_par_typ=1; then CC,0x05 -> prescale=8, par_en=1, par_typ=0.
REQ-035 AA, then 05 with rx_par_err=1, then 3C -> no write, err_cnt=2 (bad byte + unknown 0x3C in IDLE); repeat 0x11 300 times -> err_cnt=255.
REQ-036 rst asserted for one cycle during WR_DATA and during TX_SEND -> IDLE, all outputs at reset values, no strobes.
REQ-037 With RX_CMD_TIMEOUT_EN, TIMEOUT_CYC=16: AA then 16 idle cycles then 3C -> no write, err_cnt=2; the same stimulus without the macro -> write to addr 0xC pending, no error.

Source files
------------

// File: rtl/rx_cmd_ctrl.sv
// rx_cmd_ctrl: byte-oriented command decoder sitting behind a UART receiver.
// Commands: AA <addr> <data> = register write, BB <addr> = register read with
// the read data returned to the transmitter, CC <cfg> = receiver configuration.
// Bad or unexpected bytes are counted in a saturating 8-bit error counter.
// Optional build macro RX_CMD_TIMEOUT_EN adds an inter-byte timeout of
// TIMEOUT_CYC clock cycles inside multi-byte commands.
module rx_cmd_ctrl #(
    parameter int ADDR_W      = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_data_valid,
    input  logic [7:0]        rx_p_data,
    input  logic              rx_par_err,
    input  logic              rx_stp_err,
    output logic [5:0]        cfg_prescale,
    output logic              cfg_par_en,
    output logic              cfg_par_typ,
    output logic              rf_wr_en,
    output logic              rf_rd_en,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [7:0]        rf_wr_data,
    input  logic [7:0]        rf_rd_data,
    input  logic              rf_rd_valid,
    output logic [7:0]        tx_data,
    output logic              tx_data_valid,
    input  logic              tx_busy,
    output logic [7:0]        err_cnt
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WR_ADDR  = 3'd1;
    localparam logic [2:0] S_WR_DATA  = 3'd2;
    localparam logic [2:0] S_RD_ADDR  = 3'd3;
    localparam logic [2:0] S_RD_WAIT  = 3'd4;
    localparam logic [2:0] S_TX_SEND  = 3'd5;
    localparam logic [2:0] S_CFG_DATA = 3'd6;

    localparam logic [7:0] CMD_WR  = 8'hAA;
    localparam logic [7:0] CMD_RD  = 8'hBB;
    localparam logic [7:0] CMD_CFG = 8'hCC;

    logic [2:0]        r_state;
    logic [5:0]        r_prescale;
    logic              r_par_en;
    logic              r_par_typ;
    logic              r_wr_en;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wr_data;
    logic [7:0]        r_tx_data;
    logic              r_tx_vld;
    logic [7:0]        r_err_cnt;

    logic w_good;
    logic w_bad;
    logic w_timeout;
    logic w_err_inc;

    // Prescale code to oversampling ratio: 00/01/10/11 -> 4/8/16/32.
    function automatic logic [5:0] f_prescale(input logic [1:0] sel);
        case (sel)
            2'b00:   f_prescale = 6'd4;
            2'b01:   f_prescale = 6'd8;
            2'b10:   f_prescale = 6'd16;
            default: f_prescale = 6'd32;
        endcase
    endfunction

    assign w_good = rx_data_valid & ~rx_par_err & ~rx_stp_err;
    assign w_bad  = rx_data_valid & (rx_par_err | rx_stp_err);

`ifdef RX_CMD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             w_timed;

    // Only the byte-collecting states are timed; RD_WAIT/TX_SEND wait on the
    // register file and transmitter, not on the line.
    assign w_timed = (r_state == S_WR_ADDR) || (r_state == S_WR_DATA) ||
                     (r_state == S_RD_ADDR) || (r_state == S_CFG_DATA);

    assign w_timeout = w_timed && !rx_data_valid &&
                       (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    // Idle-cycle counter: clears on any byte, on timeout and outside timed
    // states, so every entry into a timed state starts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (!w_timed || rx_data_valid || w_timeout) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end
`else
    // TIMEOUT_CYC has no effect in this build; a partial command waits forever.
    localparam int unused_timeout_cyc = TIMEOUT_CYC;

    assign w_timeout = 1'b0;
`endif

    // Which events in the current state count as an error.
    always_comb begin
        w_err_inc = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_err_inc = w_bad ||
                            (w_good && (rx_p_data != CMD_WR) &&
                             (rx_p_data != CMD_RD) && (rx_p_data != CMD_CFG));
            end
            S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_CFG_DATA: begin
                w_err_inc = w_bad || w_timeout;
            end
            S_RD_WAIT, S_TX_SEND: begin
                w_err_inc = rx_data_valid;
            end
            default: w_err_inc = 1'b0;
        endcase
    end

    // Command FSM with registered strobes and outputs; strobes default low so
    // each access is a single-cycle pulse one cycle after its byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_prescale <= 6'd8;
            r_par_en   <= 1'b1;
            r_par_typ  <= 1'b0;
            r_wr_en    <= 1'b0;
            r_rd_en    <= 1'b0;
            r_addr     <= '0;
            r_wr_data  <= 8'h00;
            r_tx_data  <= 8'h00;
            r_tx_vld   <= 1'b0;
            r_err_cnt  <= 8'h00;
        end else begin
            r_wr_en <= 1'b0;
            r_rd_en <= 1'b0;
            if (w_err_inc && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_good) begin
                        case (rx_p_data)
                            CMD_WR:  r_state <= S_WR_ADDR;
                            CMD_RD:  r_state <= S_RD_ADDR;
                            CMD_CFG: r_state <= S_CFG_DATA;
                            default: r_state <= S_IDLE;
                        endcase
                    end
                end
                S_WR_ADDR: begin
                    if (w_good) begin
                        r_addr  <= rx_p_data[ADDR_W-1:0];
                        r_state <= S_WR_DATA;
                    end else if (w_bad || w_timeout) begin
                        r_state <= S_IDLE;
                    end
                end
                S_WR_DATA: begin
                    if (w_good) begin
                        r_wr_data <= rx_p_data;
                        r_wr_en   <= 1'b1;
                        r_state   <= S_IDLE;
                    end else if (w_bad || w_timeout) begin
                        r_state <= S_IDLE;
                    end
                end
                S_RD_ADDR: begin
                    if (w_good) begin
                        r_addr  <= rx_p_data[ADDR_W-1:0];
                        r_rd_en <= 1'b1;
                        r_state <= S_RD_WAIT;
                    end else if (w_bad || w_timeout) begin
                        r_state <= S_IDLE;
                    end
                end
                S_RD_WAIT: begin
                    if (rf_rd_valid) begin
                        r_tx_data <= rf_rd_data;
                        r_tx_vld  <= 1'b1;
                        r_state   <= S_TX_SEND;
                    end
                end
                S_TX_SEND: begin
                    // The reply is taken in the first cycle tx_busy is low.
                    if (!tx_busy) begin
                        r_tx_vld <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                S_CFG_DATA: begin
                    if (w_good) begin
                        r_prescale <= f_prescale(rx_p_data[1:0]);
                        r_par_en   <= rx_p_data[2];
                        r_par_typ  <= rx_p_data[3];
                        r_state    <= S_IDLE;
                    end else if (w_bad || w_timeout) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cfg_prescale  = r_prescale;
    assign cfg_par_en    = r_par_en;
    assign cfg_par_typ   = r_par_typ;
    assign rf_wr_en      = r_wr_en;
    assign rf_rd_en      = r_rd_en;
    assign rf_addr       = r_addr;
    assign rf_wr_data    = r_wr_data;
    assign tx_data       = r_tx_data;
    assign tx_data_valid = r_tx_vld;
    assign err_cnt       = r_err_cnt;

endmodule

// File: tb/tb_rx_cmd_ctrl.sv
// Testbench for rx_cmd_ctrl: directed scenarios followed by randomized
// commands checked against a command-level reference model.
module tb_rx_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_data_valid;
    logic [7:0] rx_p_data;
    logic       rx_par_err;
    logic       rx_stp_err;
    logic [5:0] cfg_prescale;
    logic       cfg_par_en;
    logic       cfg_par_typ;
    logic       rf_wr_en;
    logic       rf_rd_en;
    logic [3:0] rf_addr;
    logic [7:0] rf_wr_data;
    logic [7:0] rf_rd_data;
    logic       rf_rd_valid;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_busy;
    logic [7:0] err_cnt;

    rx_cmd_ctrl #(.ADDR_W(4), .TIMEOUT_CYC(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data_valid(rx_data_valid),
        .rx_p_data    (rx_p_data),
        .rx_par_err   (rx_par_err),
        .rx_stp_err   (rx_stp_err),
        .cfg_prescale (cfg_prescale),
        .cfg_par_en   (cfg_par_en),
        .cfg_par_typ  (cfg_par_typ),
        .rf_wr_en     (rf_wr_en),
        .rf_rd_en     (rf_rd_en),
        .rf_addr      (rf_addr),
        .rf_wr_data   (rf_wr_data),
        .rf_rd_data   (rf_rd_data),
        .rf_rd_valid  (rf_rd_valid),
        .tx_data      (tx_data),
        .tx_data_valid(tx_data_valid),
        .tx_busy      (tx_busy),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    // Reference model: command-level expectations.
    logic [7:0]  e_err;
    logic [5:0]  e_pre;
    logic        e_pen;
    logic        e_ptyp;
    logic [11:0] exp_wr[$];
    logic [11:0] obs_wr[$];
    int          n_rd_exp  = 0;
    int          n_rd_seen = 0;
    int          n_both    = 0;

    // Strobe monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (rf_wr_en) obs_wr.push_back({rf_addr, rf_wr_data});
        if (rf_rd_en) n_rd_seen++;
        if (rf_wr_en && rf_rd_en) n_both++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic pe, input logic se);
        rx_data_valid = 1'b1;
        rx_p_data     = b;
        rx_par_err    = pe;
        rx_stp_err    = se;
        tick();
        rx_data_valid = 1'b0;
        rx_p_data     = 8'($urandom);
        rx_par_err    = 1'($urandom);
        rx_stp_err    = 1'($urandom);
    endtask

    task automatic model_reset();
        e_err  = 8'd0;
        e_pre  = 6'd8;
        e_pen  = 1'b1;
        e_ptyp = 1'b0;
    endtask

    task automatic bump();
        if (e_err < 8'd255) e_err = e_err + 8'd1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".err_cnt"},  err_cnt,      e_err);
        chk({tag, ".prescale"}, cfg_prescale, e_pre);
        chk({tag, ".par_en"},   cfg_par_en,   e_pen);
        chk({tag, ".par_typ"},  cfg_par_typ,  e_ptyp);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".wr_en"},    rf_wr_en,      1'b0);
        chk({tag, ".rd_en"},    rf_rd_en,      1'b0);
        chk({tag, ".addr"},     rf_addr,       4'h0);
        chk({tag, ".wr_data"},  rf_wr_data,    8'h00);
        chk({tag, ".tx_data"},  tx_data,       8'h00);
        chk({tag, ".tx_valid"}, tx_data_valid, 1'b0);
        check_model(tag);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int gap);
        send_byte(8'hAA, 1'b0, 1'b0);
        idle(gap);
        send_byte(a, 1'b0, 1'b0);
        idle(gap);
        send_byte(d, 1'b0, 1'b0);
        chk("wr.pulse",   rf_wr_en,   1'b1);
        chk("wr.addr",    rf_addr,    a % 16);
        chk("wr.data",    rf_wr_data, d);
        exp_wr.push_back({a[3:0], d});
        tick();
        chk("wr.one_cycle", rf_wr_en, 1'b0);
    endtask

    task automatic do_cfg(input logic [7:0] b);
        send_byte(8'hCC, 1'b0, 1'b0);
        send_byte(b, 1'b0, 1'b0);
        e_pre  = 6'(4 * (1 << (b % 4)));
        e_pen  = (b / 4) % 2 == 1;
        e_ptyp = (b / 8) % 2 == 1;
        check_model("cfg");
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] d, input int busy, input bit stray);
        send_byte(8'hBB, 1'b0, 1'b0);
        send_byte(a, 1'b0, 1'b0);
        chk("rd.pulse", rf_rd_en, 1'b1);
        chk("rd.addr",  rf_addr,  a % 16);
        n_rd_exp++;
        if (stray) begin
            send_byte(8'($urandom), 1'($urandom), 1'b0);
            bump();
        end
        tick();
        chk("rd.no_reply_yet", tx_data_valid, 1'b0);
        rf_rd_valid = 1'b1;
        rf_rd_data  = d;
        tx_busy     = (busy > 0);
        tick();
        rf_rd_valid = 1'b0;
        rf_rd_data  = 8'($urandom);
        chk("tx.valid_rise", tx_data_valid, 1'b1);
        chk("tx.data",       tx_data,       d);
        for (int i = 1; i < busy; i++) begin
            if (stray && i == 1) begin
                send_byte(8'($urandom), 1'b0, 1'b0);
                bump();
            end else begin
                tick();
            end
        end
        tx_busy = 1'b0;
        chk("tx.valid_held", tx_data_valid, 1'b1);
        chk("tx.data_held",  tx_data,       d);
        tick();
        chk("tx.valid_drop", tx_data_valid, 1'b0);
    endtask

    initial begin
        logic [7:0] b;
        rst           = 1'b1;
        rx_data_valid = 1'b0;
        rx_p_data     = 8'h00;
        rx_par_err    = 1'b0;
        rx_stp_err    = 1'b0;
        rf_rd_data    = 8'h00;
        rf_rd_valid   = 1'b0;
        tx_busy       = 1'b0;
        model_reset();
        idle(2);
        rst = 1'b0;
        check_reset_outputs("reset");

        // Basic write, read with busy transmitter, configuration.
        do_write(8'h05, 8'h3C, 0);
        check_model("write");
        do_read(8'h07, 8'h5A, 10, 1'b0);
        check_model("read");
        do_cfg(8'h0B);
        chk("cfg0B.prescale", cfg_prescale, 6'd32);
        do_cfg(8'h05);
        chk("cfg05.prescale", cfg_prescale, 6'd8);

        // Aborted write plus unknown byte, then saturation.
        do_reset();
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'h05, 1'b1, 1'b0);
        bump();
        send_byte(8'h3C, 1'b0, 1'b0);
        bump();
        chk("abort.no_write", rf_wr_en, 1'b0);
        chk("abort.err_cnt",  err_cnt,  8'd2);
        send_byte(8'hCC, 1'b0, 1'b0);
        send_byte(8'h0F, 1'b0, 1'b1);
        bump();
        check_model("abort_cfg");
        for (int i = 0; i < 300; i++) begin
            send_byte(8'h11, 1'b0, 1'b0);
            bump();
        end
        chk("saturate", err_cnt, 8'd255);
        check_model("saturate");

        // Reset during WR_DATA: must land in IDLE with no write.
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'h05, 1'b0, 1'b0);
        do_reset();
        check_reset_outputs("rst_wr");
        send_byte(8'h3C, 1'b0, 1'b0);
        bump();
        chk("rst_wr.no_write", rf_wr_en, 1'b0);
        check_model("rst_wr.idle");

        // Reset during TX_SEND: reply discarded.
        send_byte(8'hBB, 1'b0, 1'b0);
        send_byte(8'h07, 1'b0, 1'b0);
        n_rd_exp++;
        rf_rd_valid = 1'b1;
        rf_rd_data  = 8'h5A;
        tx_busy     = 1'b1;
        tick();
        rf_rd_valid = 1'b0;
        chk("rst_tx.pre_valid", tx_data_valid, 1'b1);
        do_reset();
        check_reset_outputs("rst_tx");
        tx_busy = 1'b0;
        tick();
        chk("rst_tx.no_valid", tx_data_valid, 1'b0);
        chk("rst_tx.no_rd",    rf_rd_en,      1'b0);

        // Stray read return in IDLE is ignored.
        rf_rd_valid = 1'b1;
        rf_rd_data  = 8'hE7;
        tick();
        rf_rd_valid = 1'b0;
        tick();
        chk("idle_rdvalid.tx", tx_data_valid, 1'b0);

        // Inter-byte timeout behaviour.
        do_reset();
`ifdef RX_CMD_TIMEOUT_EN
        send_byte(8'hAA, 1'b0, 1'b0);
        idle(15);
        send_byte(8'h05, 1'b0, 1'b0);
        send_byte(8'h3C, 1'b0, 1'b0);
        exp_wr.push_back({4'h5, 8'h3C});
        chk("tmo.edge_write", rf_wr_en, 1'b1);
        send_byte(8'hAA, 1'b0, 1'b0);
        idle(16);
        bump();
        send_byte(8'h3C, 1'b0, 1'b0);
        bump();
        chk("tmo.no_write", rf_wr_en, 1'b0);
        chk("tmo.err_cnt",  err_cnt,  8'd2);
`else
        send_byte(8'hAA, 1'b0, 1'b0);
        idle(16);
        send_byte(8'h3C, 1'b0, 1'b0);
        chk("notmo.addr",    rf_addr, 4'hC);
        chk("notmo.err_cnt", err_cnt, 8'd0);
        idle(40);
        send_byte(8'h77, 1'b0, 1'b0);
        exp_wr.push_back({4'hC, 8'h77});
        chk("notmo.write", rf_wr_en, 1'b1);
`endif
        check_model("timeout");

        // Randomized command mix against the model.
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 5))
                0: do_write(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
                1: do_read(8'($urandom), 8'($urandom), int'($urandom_range(0, 6)), 1'($urandom));
                2: do_cfg(8'($urandom));
                3: begin
                    do b = 8'($urandom);
                    while (b == 8'hAA || b == 8'hBB || b == 8'hCC);
                    send_byte(b, 1'b0, 1'b0);
                    bump();
                end
                4: begin
                    case ($urandom_range(0, 2))
                        0: b = 8'hAA;
                        1: b = 8'hBB;
                        default: b = 8'hCC;
                    endcase
                    send_byte(b, 1'b0, 1'b0);
                    if (b == 8'hAA && $urandom_range(0, 1) == 1)
                        send_byte(8'($urandom), 1'b0, 1'b0);
                    send_byte(8'($urandom), 1'b1, 1'($urandom));
                    bump();
                    chk("rnd.abort_no_wr", rf_wr_en, 1'b0);
                    chk("rnd.abort_no_rd", rf_rd_en, 1'b0);
                end
                default: begin
                    rf_rd_valid = 1'b1;
                    rf_rd_data  = 8'($urandom);
                    tick();
                    rf_rd_valid = 1'b0;
                    tick();
                    chk("rnd.idle_rdvalid", tx_data_valid, 1'b0);
                end
            endcase
            check_model("rnd");
        end

        idle(2);
        chk("wr.count", obs_wr.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++)
            chk("wr.entry", obs_wr[i], exp_wr[i]);
        chk("rd.count",   n_rd_seen, n_rd_exp);
        chk("wr_rd_both", n_both,    0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
